// File: rtl/adc_smc_frontend_if.sv
// Sample/result handshake bundle for adc_smc_frontend.
// o_sat exists only when ADC_SAT_FLAG_EN is defined.
interface adc_smc_frontend_if;
  logic        i_srdyi;
  logic [20:0] i_x;
  logic        o_rtro;
  logic [31:0] o_y;
  logic [1:0]  o_section;
  logic        o_srdyo;
  logic        i_rtri;
`ifdef ADC_SAT_FLAG_EN
  logic        o_sat;
`endif

  modport slave (
    input  i_srdyi, i_x, i_rtri,
`ifdef ADC_SAT_FLAG_EN
    output o_sat,
`endif
    output o_rtro, o_y, o_section, o_srdyo
  );

  modport master (
    output i_srdyi, i_x, i_rtri,
`ifdef ADC_SAT_FLAG_EN
    input  o_sat,
`endif
    input  o_rtro, o_y, o_section, o_srdyo
  );
endinterface

// File: rtl/adc_smc_frontend.sv
// ADC count -> sign-magnitude float converter with section index, normalising one bit per cycle.
// Optional full-scale flag o_sat under macro ADC_SAT_FLAG_EN.
module adc_smc_frontend #(
  parameter int SECT_BOUND = 44978
) (
  input  logic               i_clk,
  input  logic               i_reset,
  adc_smc_frontend_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CAPT, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [20:0] x_q, x_d;
  logic [20:0]        mag_q, mag_d;
  logic               sign_q, sign_d;
  logic [7:0]         exp_q, exp_d;
  logic [31:0]        y_q, y_d;
  logic [1:0]         sec_q, sec_d;
`ifdef ADC_SAT_FLAG_EN
  logic               sat_q, sat_d;
`endif
  int                 xv;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    y_d     = y_q;
    sec_d   = sec_q;
`ifdef ADC_SAT_FLAG_EN
    sat_d   = sat_q;
`endif
    xv      = int'(x_q);
    case (state_q)
      IDLE: if (bus.i_srdyi) begin
        x_d     = bus.i_x;
        state_d = CAPT;
      end
      CAPT: begin
        sign_d = xv < 0;
        // 21-bit truncation maps -2^20 onto 2^20 exactly
        mag_d  = 21'(xv < 0 ? -xv : xv);
        exp_d  = 8'd147;
        if (xv <= -SECT_BOUND)     sec_d = 2'd0;
        else if (xv <= 0)          sec_d = 2'd1;
        else if (xv <= SECT_BOUND) sec_d = 2'd2;
        else                       sec_d = 2'd3;
`ifdef ADC_SAT_FLAG_EN
        sat_d  = (xv == -1048576) || (xv == 1048575);
`endif
        if (xv == 0) begin
          y_d     = '0;
          state_d = DONE;
        end else begin
          state_d = NORM;
        end
      end
      NORM: if (mag_q[20]) begin
        y_d     = {sign_q, exp_q, mag_q[19:0], 3'b000};
        state_d = DONE;
      end else begin
        mag_d = mag_q << 1;
        exp_d = exp_q - 8'd1;
      end
      DONE: if (bus.i_rtri) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      y_q     <= '0;
      sec_q   <= '0;
`ifdef ADC_SAT_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      y_q     <= y_d;
      sec_q   <= sec_d;
`ifdef ADC_SAT_FLAG_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.o_rtro    = (state_q == IDLE);
  assign bus.o_srdyo   = (state_q == DONE);
  assign bus.o_y       = y_q;
  assign bus.o_section = sec_q;
`ifdef ADC_SAT_FLAG_EN
  assign bus.o_sat     = sat_q;
`endif

endmodule
